// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
//   Pipelined immediate extender. It sits between decode and the D/E register.
//   The raw immediate is extended according to in_op and registered into an
//   output stage (M). A single skid register (S) catches one beat under
//   back-pressure, so in_ready is a flop and never depends combinationally on
//   out_ready.
//
//   Modes (in_op):
//     000 zero-extend
//     001 sign-extend
//     010 immediate in the top IN_W bits, low bits zero
//     011 sign-extend, then << 2 (branch offset)
//     100 zero-extend, then << 2 (jump offset)
//     1x1/110 illegal: zero-extend result, out_op_err = 1
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   flush       synchronous pipeline flush; drops M, S and any same-cycle input
//   in_valid    input beat valid
//   in_ready    unit can accept a beat (registered)
//   in_imm      raw immediate, IN_W bits
//   in_op       extension mode, 3 bits
//   in_tag      sideband tag, passed through unchanged
//   out_valid   output beat valid
//   out_ready   downstream accepts the beat
//   out_data    extended result, OUT_W bits
//   out_tag     tag of the beat on out_data
//   out_op_err  beat on out_data came from an illegal in_op

module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_op_err
);

  localparam int PAD_W = OUT_W - IN_W;

  // The shift modes need two spare bits above the immediate.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_SIGN = 3'b001;
  localparam logic [2:0] OP_HIGH = 3'b010;
  localparam logic [2:0] OP_BOFS = 3'b011;
  localparam logic [2:0] OP_JOFS = 3'b100;

  // Extension datapath
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] new_data;
  logic             new_err;

  assign ext_zero = {{PAD_W{1'b0}}, in_imm};
  assign ext_sign = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    new_data = ext_zero;
    new_err  = 1'b0;
    case (in_op)
      OP_ZERO: new_data = ext_zero;
      OP_SIGN: new_data = ext_sign;
      OP_HIGH: new_data = {in_imm, {PAD_W{1'b0}}};
      OP_BOFS: new_data = ext_sign << 2;
      OP_JOFS: new_data = ext_zero << 2;
      default: begin
        new_data = ext_zero;
        new_err  = 1'b1;
      end
    endcase
  end

  // Storage: main (M) and skid (S) registers
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             m_err;

  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic [TAG_W-1:0] s_tag;
  logic             s_err;

  logic             in_ready_q;

  // Control
  logic in_xfer;
  logic m_free;
  logic m_load_s;
  logic m_load_in;
  logic s_load_in;
  logic m_valid_nxt;
  logic s_valid_nxt;

  always_comb begin
    // Flush drops the same-cycle input even when in_ready is high.
    in_xfer     = in_valid && in_ready_q && !flush;
    // M can take a new beat when empty or when its beat leaves this edge.
    m_free      = !m_valid || out_ready;
    m_load_s    = m_free && s_valid;
    m_load_in   = m_free && !s_valid && in_xfer;
    // S takes the input when M is stalled, or (unreachable while in_ready
    // tracks !s_valid) when S is also draining into M.
    s_load_in   = in_xfer && (s_valid || !m_free);

    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    if (flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else begin
      if (m_free) begin
        m_valid_nxt = s_valid || in_xfer;
      end
      if (s_load_in) begin
        s_valid_nxt = 1'b1;
      end else if (m_free) begin
        s_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_tag      <= '0;
      m_err      <= 1'b0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_tag      <= '0;
      s_err      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_valid    <= m_valid_nxt;
      s_valid    <= s_valid_nxt;
      in_ready_q <= !s_valid_nxt;

      if (m_load_s) begin
        m_data <= s_data;
        m_tag  <= s_tag;
        m_err  <= s_err;
      end else if (m_load_in) begin
        m_data <= new_data;
        m_tag  <= in_tag;
        m_err  <= new_err;
      end

      if (s_load_in) begin
        s_data <= new_data;
        s_tag  <= in_tag;
        s_err  <= new_err;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_valid;
  assign out_data   = m_data;
  assign out_tag    = m_tag;
  assign out_op_err = m_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe (IN_W=16, OUT_W=32, TAG_W=5).
// The driver pushes the expected beat into a scoreboard queue when a beat is
// accepted; an independent monitor pops and compares on every output transfer
// and checks that a stalled output beat holds steady.

module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_op_err;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_op_err (out_op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rand_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference formulas, 16 -> 32. Returns {err, data}.
  function automatic logic [32:0] model(logic [15:0] imm, logic [2:0] op);
    logic [31:0] z;
    logic [31:0] s;
    z = {16'h0000, imm};
    s = {{16{imm[15]}}, imm};
    case (op)
      3'd0:    return {1'b0, z};
      3'd1:    return {1'b0, s};
      3'd2:    return {1'b0, imm, 16'h0000};
      3'd3:    return {1'b0, s[29:0], 2'b00};
      3'd4:    return {1'b0, z[29:0], 2'b00};
      default: return {1'b1, z};
    endcase
  endfunction

  // Called at a negedge; returns at a later negedge with in_valid low.
  task automatic send(logic [15:0] imm, logic [2:0] op, logic [4:0] tag,
                      logic [31:0] ed, logic ee);
    int   w;
    exp_t e;
    w = 0;
    in_imm   = imm;
    in_op    = op;
    in_tag   = tag;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, tag %0d not accepted", tag);
      in_valid = 1'b0;
      return;
    end
    e.data    = ed;
    e.tag     = tag;
    e.err     = ee;
    e.acc_cyc = cyc;
    e.chk_lat = lat_mode;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(logic [4:0] tag);
    logic [15:0] imm;
    logic [2:0]  op;
    logic [32:0] r;
    imm = 16'($urandom);
    op  = 3'($urandom_range(0, 7));
    r   = model(imm, op);
    send(imm, op, tag, r[31:0], r[32]);
  endtask

  // Monitor
  initial begin
    bit          held;
    logic [31:0] hd;
    logic [4:0]  ht;
    logic        he;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset || flush) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", out_data, hd);
          check("stall_tag", 32'(out_tag), 32'(ht));
          check("stall_err", 32'(out_op_err), 32'(he));
        end
        held = 1'b0;
        if (out_valid && !out_ready) begin
          held = 1'b1;
          hd   = out_data;
          ht   = out_tag;
          he   = out_op_err;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h tag %0d, expected no beat",
                     out_data, out_tag);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", 32'(out_tag), 32'(e.tag));
            check("out_op_err", 32'(out_op_err), 32'(e.err));
            if (e.chk_lat) check("latency", 32'(cyc), 32'(e.acc_cyc + 1));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Streaming all legal modes on 0x8001, with latency checks
    lat_mode = 1'b1;
    send(16'h8001, 3'b000, 5'd1, 32'h0000_8001, 1'b0);
    send(16'h8001, 3'b001, 5'd2, 32'hFFFF_8001, 1'b0);
    send(16'h8001, 3'b010, 5'd3, 32'h8001_0000, 1'b0);
    send(16'h8001, 3'b011, 5'd4, 32'hFFFE_0004, 1'b0);
    send(16'h8001, 3'b100, 5'd5, 32'h0002_0004, 1'b0);
    send(16'hF00F, 3'b110, 5'd6, 32'h0000_F00F, 1'b1);
    send(16'h7FFF, 3'b001, 5'd7, 32'h0000_7FFF, 1'b0);
    send(16'h0001, 3'b111, 5'd8, 32'h0000_0001, 1'b1);
    send(16'h4000, 3'b011, 5'd9, 32'h0001_0000, 1'b0);
    lat_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Back-pressure: tag 1 in M, tag 2 in S, tag 3 held off
    out_ready = 1'b0;
    send(16'h1111, 3'b000, 5'd1, 32'h0000_1111, 1'b0);
    send(16'h2222, 3'b001, 5'd2, 32'h0000_2222, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_tag", 32'(out_tag), 32'd1);
    in_imm   = 16'h3333;
    in_op    = 3'b010;
    in_tag   = 5'd3;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    check("bp_out_data_hold", out_data, 32'h0000_1111);
    out_ready = 1'b1;
    send(16'h3333, 3'b010, 5'd3, 32'h3333_0000, 1'b0);
    repeat (4) @(negedge clk);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Flush with M and S full and a same-cycle input
    out_ready = 1'b0;
    send(16'hAAAA, 3'b000, 5'd4, 32'h0000_AAAA, 1'b0);
    send(16'hBBBB, 3'b000, 5'd5, 32'h0000_BBBB, 1'b0);
    in_imm   = 16'hCCCC;
    in_tag   = 5'd6;
    in_valid = 1'b1;
    flush    = 1'b1;
    sb.delete();
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);

    // Flush with only M full: an input with in_ready=1 is dropped too
    send(16'hDDDD, 3'b000, 5'd7, 32'h0000_DDDD, 1'b0);
    in_imm   = 16'hEEEE;
    in_tag   = 5'd8;
    in_valid = 1'b1;
    flush    = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("flush2_no_stale", 32'(out_valid), 32'd0);
    send(16'h0123, 3'b100, 5'd9, 32'h0000_048C, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-stall with both registers full
    out_ready = 1'b0;
    send(16'h5555, 3'b001, 5'd10, 32'h0000_5555, 1'b0);
    send(16'h6666, 3'b001, 5'd11, 32'h0000_6666, 1'b0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_out_data", out_data, 32'd0);
    check("rst2_out_tag", 32'(out_tag), 32'd0);
    check("rst2_out_err", 32'(out_op_err), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("rst2_in_ready_held", 32'(in_ready), 32'd0);
    check("rst2_out_valid_held", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_rel_in_ready", 32'(in_ready), 32'd1);
    send(16'h8001, 3'b001, 5'd12, 32'hFFFF_8001, 1'b0);
    repeat (3) @(negedge clk);

    // Randomised valid/ready, 1000 beats
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rand(5'(i));
    end
    rand_on = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("rand_drained", 32'(sb.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
